// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch path
package core_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] ins;
  } fetch_ent_t;

endpackage

// File: rtl/ifu_skid_fifo.sv
// rtl/ifu_skid_fifo.sv - 2-entry skid FIFO holding fetched {pc, ins} pairs
module ifu_skid_fifo
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_ent_t din,
  output fetch_ent_t dout,
  output logic [1:0] count
);

  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_count;
  fetch_ent_t r_mem [2];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push) r_wp <= ~r_wp;
      if (pop)  r_rp <= ~r_rp;
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Push into a full FIFO is legal only when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wp] <= din;
  end

  assign dout  = r_mem[r_rp];
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
    !(push && !pop && !flush && (r_count == 2'd2)));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - RV32 fetch controller: PC, SRAM request, epoch-tagged
// responses and output register backed by a 2-entry skid FIFO
module ifu_fetch_ctrl
  import core_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [AW-1:0] ins_a,
  output logic          ins_e,
  input  logic [31:0]   ins,
  input  logic          stall,
  input  logic          branch,
  input  logic [AW-1:0] branch_pc,
  output logic          ifu_vld,
  output logic [AW-1:0] ifu_pc,
  output logic [31:0]   ifu_ins
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_rq_pc;
  logic          r_rq_vld;
  logic          r_rq_ep;
  logic          r_epoch;
  logic          r_vld;
  logic [AW-1:0] r_out_pc;
  logic [31:0]   r_out_ins;

  logic [1:0]    w_fifo_cnt;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic [AW-1:0] w_fetch_a;
  logic          w_rsp_ok;
  logic          w_adv;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  fetch_ent_t    w_head;
  fetch_ent_t    w_rsp;

  // Credits: every slot a fetch could land in is either buffered or in flight.
  assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_rq_vld} + {2'b00, r_vld & stall};
  assign w_issue   = !rstn && (branch || (w_occ < 3'd3));
  assign w_fetch_a = branch ? (branch_pc & ~AW'(3)) : r_pc;

  assign ins_a = rstn ? r_pc : w_fetch_a;
  assign ins_e = w_issue;

  assign w_rsp_ok     = r_rq_vld && (r_rq_ep == r_epoch) && !branch;
  assign w_adv        = !r_vld || !stall;
  assign w_fifo_empty = (w_fifo_cnt == 2'd0);
  assign w_pop        = !branch && w_adv && !w_fifo_empty;
  assign w_push       = w_rsp_ok && !(w_adv && w_fifo_empty);
  assign w_rsp        = '{pc: r_rq_pc, ins: ins};

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_pc     <= RESET_PC;
      r_rq_vld <= 1'b0;
      r_rq_pc  <= '0;
      r_rq_ep  <= 1'b0;
      r_epoch  <= 1'b0;
    end else begin
      r_rq_vld <= w_issue;
      if (w_issue) begin
        r_pc    <= w_fetch_a + AW'(4);
        r_rq_pc <= w_fetch_a;
        r_rq_ep <= r_epoch ^ branch;
      end
      if (branch) r_epoch <= ~r_epoch;
    end
  end

  // FIFO head always wins over a same-cycle response to keep program order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_vld     <= 1'b0;
      r_out_pc  <= '0;
      r_out_ins <= '0;
    end else if (branch) begin
      r_vld <= 1'b0;
    end else if (w_adv) begin
      if (!w_fifo_empty) begin
        r_vld     <= 1'b1;
        r_out_pc  <= w_head.pc;
        r_out_ins <= w_head.ins;
      end else if (w_rsp_ok) begin
        r_vld     <= 1'b1;
        r_out_pc  <= w_rsp.pc;
        r_out_ins <= w_rsp.ins;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  ifu_skid_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .flush (branch),
    .din   (w_rsp),
    .dout  (w_head),
    .count (w_fifo_cnt)
  );

  assign ifu_vld = r_vld;
  assign ifu_pc  = r_out_pc;
  assign ifu_ins = r_out_ins;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] branch_pc = 16'h0;

  logic [15:0] ins_a, ifu_pc, h_ins_a, h_ifu_pc;
  logic        ins_e, ifu_vld, h_ins_e, h_ifu_vld;
  logic [31:0] ins, ifu_ins, h_ins, h_ifu_ins;

  int          vectors = 0;
  int          miscompares = 0;
  logic        sb_en = 1'b0;
  logic [15:0] exp_pc = 16'h0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl u_dut (
    .clk(clk), .rstn(rstn), .ins_a(ins_a), .ins_e(ins_e), .ins(ins),
    .stall(stall), .branch(branch), .branch_pc(branch_pc),
    .ifu_vld(ifu_vld), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins)
  );

  ifu_fetch_ctrl #(.RESET_PC(16'hFFF8)) u_hi (
    .clk(clk), .rstn(rstn), .ins_a(h_ins_a), .ins_e(h_ins_e), .ins(h_ins),
    .stall(stall), .branch(branch), .branch_pc(branch_pc),
    .ifu_vld(h_ifu_vld), .ifu_pc(h_ifu_pc), .ifu_ins(h_ifu_ins)
  );

  // Program image: the four test-plan words at 0..C, an address-derived pattern elsewhere.
  function automatic logic [31:0] wordf(input logic [15:0] a);
    logic [31:0] i;
    i = {18'h0, a[15:2]};
    if (a < 16'd16) return (i << 20) | (i << 7) | 32'h13;
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    ins   <= ins_e   ? wordf(ins_a)   : $urandom;
    h_ins <= h_ins_e ? wordf(h_ins_a) : $urandom;
  end

  // Reference: accepted instructions must be consecutive words from the last redirect.
  always @(negedge clk) begin
    #2;
    if (sb_en) begin
      if (rstn) exp_pc = 16'h0000;
      else if (branch) exp_pc = branch_pc & 16'hFFFC;
      else if (ifu_vld && !stall) begin
        vectors++;
        if (ifu_pc !== exp_pc || ifu_ins !== wordf(exp_pc)) begin
          miscompares++;
          $display("FAIL order: got pc=%h ins=%h, expected pc=%h ins=%h",
                   ifu_pc, ifu_ins, exp_pc, wordf(exp_pc));
        end
        exp_pc = exp_pc + 16'd4;
      end
    end
  end

  task automatic drive(input logic st, input logic br, input logic [15:0] bpc);
    @(negedge clk);
    stall = st; branch = br; branch_pc = bpc;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) drive(1'b0, 1'b0, 16'h0);
    vectors++;
    if (ins_e !== 1'b0 || ins_a !== 16'h0 || h_ins_a !== 16'hFFF8) begin
      miscompares++;
      $display("FAIL reset_req: ins_e=%b ins_a=%h hi_ins_a=%h, expected 0/0000/fff8", ins_e, ins_a, h_ins_a);
    end
    vectors++;
    if (ifu_vld !== 1'b0 || ifu_pc !== 16'h0 || ifu_ins !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out: vld=%b pc=%h ins=%h, expected 0/0000/00000000", ifu_vld, ifu_pc, ifu_ins);
    end
    @(negedge clk); rstn = 1'b0; #1;
    vectors++;
    if (ins_e !== 1'b1 || ins_a !== 16'h0) begin
      miscompares++;
      $display("FAIL first_fetch: ins_e=%b ins_a=%h, expected 1/0000", ins_e, ins_a);
    end
    drive(1'b0, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b0 || ins_a !== 16'h4) begin
      miscompares++;
      $display("FAIL latency: vld=%b ins_a=%h, expected 0/0004", ifu_vld, ins_a);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'h0);
      vectors++;
      if (ifu_vld !== 1'b1 || ifu_pc !== 16'(4 * k) || ifu_ins !== wordf(16'(4 * k))) begin
        miscompares++;
        $display("FAIL stream%0d: vld=%b pc=%h ins=%h, expected 1/%h/%h",
                 k, ifu_vld, ifu_pc, ifu_ins, 16'(4 * k), wordf(16'(4 * k)));
      end
    end
  endtask

  task automatic test_stall;
    logic found;
    found = 1'b0;
    @(negedge clk); rstn = 1'b1; #1;
    @(negedge clk); rstn = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      if (ifu_vld && ifu_pc == 16'h4) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL stall_sync: pc 0004 not seen, got pc=%h", ifu_pc);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 16'h0);
      vectors++;
      if (ifu_vld !== 1'b1 || ifu_pc !== 16'h8 || (k >= 2 && ins_e !== 1'b0)) begin
        miscompares++;
        $display("FAIL stall_hold%0d: vld=%b pc=%h ins_e=%b, expected 1/0008/%s",
                 k, ifu_vld, ifu_pc, ins_e, (k >= 2) ? "0" : "-");
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'h0);
      vectors++;
      if (ifu_vld !== 1'b1 || ifu_pc !== 16'(8 + 4 * k)) begin
        miscompares++;
        $display("FAIL stall_release%0d: vld=%b pc=%h, expected 1/%h", k, ifu_vld, ifu_pc, 16'(8 + 4 * k));
      end
    end
  endtask

  task automatic test_branch;
    repeat (3) drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h0102);
    vectors++;
    if (ins_a !== 16'h0100 || ins_e !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_req: ins_a=%h ins_e=%b, expected 0100/1", ins_a, ins_e);
    end
    drive(1'b0, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_bubble: vld=%b, expected 0", ifu_vld);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 16'h0);
      vectors++;
      if (ifu_vld !== 1'b1 || ifu_pc !== 16'(16'h100 + 4 * k)) begin
        miscompares++;
        $display("FAIL branch_target%0d: vld=%b pc=%h, expected 1/%h", k, ifu_vld, ifu_pc, 16'(16'h100 + 4 * k));
      end
    end
  endtask

  task automatic test_branch_stall_full;
    repeat (6) drive(1'b1, 1'b0, 16'h0);
    vectors++;
    if (ins_e !== 1'b0) begin
      miscompares++;
      $display("FAIL credits: ins_e=%b, expected 0", ins_e);
    end
    drive(1'b1, 1'b1, 16'h0200);
    vectors++;
    if (ins_e !== 1'b1 || ins_a !== 16'h0200) begin
      miscompares++;
      $display("FAIL bsf_req: ins_e=%b ins_a=%h, expected 1/0200", ins_e, ins_a);
    end
    drive(1'b1, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL bsf_bubble: vld=%b, expected 0", ifu_vld);
    end
    drive(1'b1, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b1 || ifu_pc !== 16'h0200) begin
      miscompares++;
      $display("FAIL bsf_target: vld=%b pc=%h, expected 1/0200", ifu_vld, ifu_pc);
    end
    drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b1 || ifu_pc !== 16'h0204) begin
      miscompares++;
      $display("FAIL bsf_flushed: vld=%b pc=%h, expected 1/0204", ifu_vld, ifu_pc);
    end
  endtask

  task automatic test_wrap;
    logic found;
    found = 1'b0;
    @(negedge clk); rstn = 1'b1; stall = 1'b0; branch = 1'b0; #1;
    @(negedge clk); rstn = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      if (h_ifu_vld) found = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (h_ifu_vld !== 1'b1 || h_ifu_pc !== 16'(16'hFFF8 + 4 * k) || h_ifu_ins !== wordf(16'(16'hFFF8 + 4 * k))) begin
        miscompares++;
        $display("FAIL wrap%0d: vld=%b pc=%h ins=%h, expected 1/%h/%h", k, h_ifu_vld, h_ifu_pc, h_ifu_ins,
                 16'(16'hFFF8 + 4 * k), wordf(16'(16'hFFF8 + 4 * k)));
      end
      drive(1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic test_reset_mid;
    repeat (6) drive(1'b1, 1'b0, 16'h0);
    @(negedge clk); rstn = 1'b1; #1;
    vectors++;
    if (ins_e !== 1'b0 || ins_a !== 16'h0 || ifu_vld !== 1'b0 || ifu_pc !== 16'h0 || ifu_ins !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: ins_e=%b ins_a=%h vld=%b pc=%h ins=%h, expected all zero",
               ins_e, ins_a, ifu_vld, ifu_pc, ifu_ins);
    end
    drive(1'b0, 1'b0, 16'h0);
    @(negedge clk); rstn = 1'b0; #1;
    vectors++;
    if (ins_e !== 1'b1 || ins_a !== 16'h0) begin
      miscompares++;
      $display("FAIL restart_req: ins_e=%b ins_a=%h, expected 1/0000", ins_e, ins_a);
    end
    drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0);
    vectors++;
    if (ifu_vld !== 1'b1 || ifu_pc !== 16'h0) begin
      miscompares++;
      $display("FAIL restart_out: vld=%b pc=%h, expected 1/0000", ifu_vld, ifu_pc);
    end
  endtask

  task automatic test_random;
    logic        st, br, prev_br, found;
    logic [15:0] bpc;
    prev_br = 1'b0;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom % 10) < 3;
      br  = ($urandom % 16) == 0;
      bpc = 16'($urandom);
      drive(st, br, bpc);
      if (br) begin
        vectors++;
        if (ins_e !== 1'b1 || ins_a !== (bpc & 16'hFFFC)) begin
          miscompares++;
          $display("FAIL rnd_branch: ins_e=%b ins_a=%h, expected 1/%h", ins_e, ins_a, bpc & 16'hFFFC);
        end
      end else if (prev_br) begin
        vectors++;
        if (ifu_vld !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_bubble: vld=%b, expected 0", ifu_vld);
        end
      end
      prev_br = br;
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      if (ifu_vld) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rnd_live: vld=%b, expected 1 within 8 cycles", ifu_vld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sb_en = 1'b1;
    test_reset();
    test_stall();
    test_branch();
    test_branch_stall_full();
    test_wrap();
    test_reset_mid();
    test_random();
    drive(1'b0, 1'b0, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction fetch controller of the RV32 core: owns the PC, drives the instruction SRAM port (`ins_a`/`ins_e`/`ins`), and delivers `{ifu_pc, ifu_ins}` with `ifu_vld` to the decode/execute stage.
- Absorbs the SRAM's fixed 1-cycle read latency and downstream stalls through a 2-entry skid FIFO.
- Redirects on `branch`, discarding every wrong-path fetch.

## Interface
- `RESET_PC`, 16'h0000: first fetch address after reset; bits [1:0] must be 0.
- `AW`, 16: instruction byte-address width.
- `clk`  in  1: clock clk.
- `rstn`  in  1: reset rstn, asynchronous, active-high.
- `ins_a`  out  AW: SRAM byte address; the SRAM uses [15:2].
- `ins_e`  out  1: SRAM read enable, sampled with `ins_a` at posedge.
- `ins`  in  32: SRAM read data; valid the cycle after the sampling edge.
- `stall`  in  1: downstream not ready; output holds.
- `branch`  in  1: redirect request, single-cycle pulse.
- `branch_pc`  in  AW: redirect target; bits [1:0] are ignored and treated as 0.
- `ifu_vld`  out  1: output instruction valid.
- `ifu_pc`  out  AW: PC of `ifu_ins`.
- `ifu_ins`  out  32: instruction word.

## Operation
- State:
  - `pc` (next sequential fetch address).
  - In-flight request tag: `rq_vld`, `rq_pc`, `rq_ep`.
  - 1-bit `epoch`.
  - 2-entry FIFO of `{pc, ins}`.
  - Output register `{ifu_vld, ifu_pc, ifu_ins}`.
- Credits: `occ = fifo_count + rq_vld + (ifu_vld & stall)`.
- Issue when `occ < 3` or `branch` is 1.
  - On issue: `ins_e=1`, and `rq_*` is loaded next edge.
  - Otherwise `ins_e=0`.
- Address select:
  - `ins_a = branch ? {branch_pc[AW-1:2],2'b00} : pc`.
  - On issue, `pc <= ins_a + 4`.
  - Addition is modulo 2^AW: 16'hFFFC wraps to 16'h0000.
- Response: in the cycle after an issue, `ins` is paired with `rq_pc`.
  - Dropped if `rq_ep != epoch` or `branch` is 1 this cycle.
  - Otherwise it goes to the output register if that register is free (`!ifu_vld | !stall`) and the FIFO is empty.
  - Otherwise it is pushed to the FIFO.
- Output advance (`!stall` or `!ifu_vld`): load from the FIFO head if nonempty, else from the accepted response, else clear `ifu_vld`.
- Order is strictly program order: FIFO entries precede a same-cycle response.
- Branch, at cycle N:
  - `epoch` toggles.
  - FIFO flushed.
  - `ifu_vld <= 0` at the N edge, regardless of `stall`.
  - The new request (`branch_pc`) issues in N with the new epoch.
  - `branch` has priority over `stall` and over a full credit count.
- Downstream treats `ifu_vld` in the branch cycle as killed (`ifu_vld & !branch`).
- The FIFO never overflows: pushing while full is an assertion failure.

## Timing
- Reset values:
  - `pc=RESET_PC`, `ins_a=RESET_PC`, `ins_e=0`.
  - `ifu_vld=0`, `ifu_pc=0`, `ifu_ins=0`.
  - `rq_vld=0`, `epoch=0`, FIFO empty.
- First cycle after reset release: `ins_e=1`, `ins_a=RESET_PC`.
- Fetch-to-output latency, no stall: issue in cycle N, data on `ins` in N+1, `ifu_vld/ifu_pc/ifu_ins` registered at the N+1 edge.
  - Steady-state throughput is 1 instruction/cycle.
- Branch in cycle N: first target instruction is valid after the N+1 edge, a 1-bubble penalty.
- `stall` held high: at most 3 instructions buffered (output register, 2 FIFO entries); `ins_e` drops once credits are exhausted.
  - On `stall` release, output advances every cycle from the FIFO with no bubble.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight data is ignored.
- `branch` and `stall` both high: the flush wins, and `ifu_vld` is 0 next cycle.
- `branch` arriving in the cycle a response returns: that response is dropped.

## Structure
- Shared `core_pkg` holds:
  - `RESET_PC` default.
  - `NOP` (32'h0000_0013), for debug only.
  - typedef `fetch_ent_t` = `{logic [15:0] pc; logic [31:0] ins;}`.
- Sub-module `ifu_skid_fifo`:
  - 2-entry, 1-bit pointers, count output.
  - Ports: push, pop, flush, `fetch_ent_t` in/out.
- Top holds PC, epoch, credit logic and the output register.

## Test plan
- Reset release, SRAM words 0..3 = 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193 → `ifu_pc` 0,4,8,C on consecutive cycles; first `ifu_vld` one edge after first `ins_e`.
- `stall` high 5 cycles mid-stream at `ifu_pc`=8 → `ifu_pc` holds 8, `ins_e` low after 2 cycles; on release 8,C,10,14 appear back-to-back with no gap or duplicate.
- `branch` with `branch_pc`=16'h0102 while streaming → `ins_a`=16'h0100 same cycle; `ifu_vld`=0 next cycle; then `ifu_pc`=100,104; no pre-branch PC appears after.
- `branch` with `stall` high and FIFO full → FIFO flushed, `ifu_vld`=0 next cycle, `ifu_pc`=branch target one cycle later.
- `RESET_PC`=16'hFFF8, free run → `ifu_pc` FFF8, FFFC, 0000, 0004.
- `rstn` pulsed high during a stalled, full state → all outputs at reset values within the same cycle; fetch restarts at `RESET_PC`.
